// File: rtl/fetch_stage.sv
// Instruction fetch stage: a single-outstanding-request fetch FSM feeding the IF/ID pipeline register.
// Responses can be parked in a hold buffer while stalled, or dropped after a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nxt_pc,
  input  logic        br_flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc4F,
  output logic [31:0] instrF,
  output logic        instr_vldF,
  output logic [31:0] pcD,
  output logic [31:0] pc4D,
  output logic [31:0] instrD,
  output logic        vldD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic [31:0] instrd_q, instrd_d;
  logic        vldd_q, vldd_d;
  logic        complete_s;
  logic [31:0] fetch_instr_s;
  logic [31:0] pc_next_s;

  // Fetch addresses are always word aligned.
  assign pc_next_s = {nxt_pc[31:2], 2'b00};

  // State, PC and IF/ID register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      hold_q   <= 32'h0000_0000;
      pcd_q    <= 32'h0000_0000;
      pc4d_q   <= 32'h0000_0000;
      instrd_q <= NOP_INSTR;
      vldd_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      pcd_q    <= pcd_d;
      pc4d_q   <= pc4d_d;
      instrd_q <= instrd_d;
      vldd_q   <= vldd_d;
    end
  end

  // Fetch FSM next-state, PC redirect and hold-buffer capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    complete_s    = 1'b0;
    fetch_instr_s = hold_q;
    case (state_q)
      S_REQ: begin
        if (br_flush) begin
          pc_d    = pc_next_s;
          // A granted request on a redirect must still be drained.
          state_d = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (br_flush) begin
          pc_d    = pc_next_s;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid && stall) begin
          hold_d  = imem_rdata;
          state_d = S_HOLD;
        end else if (imem_rvalid) begin
          complete_s    = 1'b1;
          fetch_instr_s = imem_rdata;
          pc_d          = pc_next_s;
          state_d       = S_REQ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (br_flush) begin
          pc_d    = pc_next_s;
          state_d = S_REQ;
        end else if (!stall) begin
          complete_s    = 1'b1;
          fetch_instr_s = hold_q;
          pc_d          = pc_next_s;
          state_d       = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (br_flush) begin
          pc_d = pc_next_s;
        end else begin
          pc_d = pc_q;
        end
        state_d = imem_rvalid ? S_REQ : S_DROP;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // IF/ID register: flush > stall > completed fetch > bubble.
  always_comb begin
    pcd_d    = pcd_q;
    pc4d_d   = pc4d_q;
    instrd_d = instrd_q;
    vldd_d   = vldd_q;
    if (br_flush) begin
      instrd_d = NOP_INSTR;
      vldd_d   = 1'b0;
    end else if (stall) begin
      vldd_d = vldd_q;
    end else if (complete_s) begin
      pcd_d    = pc_q;
      pc4d_d   = pc_q + 32'd4;
      instrd_d = fetch_instr_s;
      vldd_d   = 1'b1;
    end else begin
      instrd_d = NOP_INSTR;
      vldd_d   = 1'b0;
    end
  end

  // Fetch-side outputs; the response is forwarded to the predictor in the cycle it arrives.
  always_comb begin
    imem_req   = (state_q == S_REQ) && !rst;
    instrF     = NOP_INSTR;
    instr_vldF = 1'b0;
    if (state_q == S_WAIT && imem_rvalid) begin
      instrF     = imem_rdata;
      instr_vldF = 1'b1;
    end else if (state_q == S_HOLD) begin
      instrF     = hold_q;
      instr_vldF = 1'b1;
    end else begin
      instrF     = NOP_INSTR;
      instr_vldF = 1'b0;
    end
  end

  assign imem_addr = pc_q;
  assign pcF       = pc_q;
  assign pc4F      = pc_q + 32'd4;
  assign pcD       = pcd_q;
  assign pc4D      = pc4d_q;
  assign instrD    = instrd_q;
  assign vldD      = vldd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] nxt_pc = 32'h0;
  logic        br_flush = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pcF, pc4F, instrF, pcD, pc4D, instrD;
  logic        instr_vldF, vldD;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  ifid_t       sb_q[$];
  ifid_t       exp_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_instr = 32'h0;
  logic [31:0] data_v;

  fetch_stage dut (
    .clk(clk), .rst(rst), .nxt_pc(nxt_pc), .br_flush(br_flush), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcF(pcF), .pc4F(pc4F), .instrF(instrF), .instr_vldF(instr_vldF),
    .pcD(pcD), .pc4D(pc4D), .instrD(instrD), .vldD(vldD)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
    vectors++; if (pcF !== 32'h0) begin miscompares++; $display("FAIL rst_pcF got=%h exp=00000000", pcF); end
    vectors++; if (vldD !== 1'b0) begin miscompares++; $display("FAIL rst_vldD got=%0h exp=0", vldD); end
    vectors++; if (instrD !== NOP) begin miscompares++; $display("FAIL rst_instrD got=%h exp=%h", instrD, NOP); end
    vectors++; if (pcD !== 32'h0 || pc4D !== 32'h0) begin miscompares++; $display("FAIL rst_pcD got=%h/%h exp=0/0", pcD, pc4D); end
    vectors++; if (instr_vldF !== 1'b0 || instrF !== NOP) begin miscompares++; $display("FAIL rst_instrF got=%h/%0h exp=%h/0", instrF, instr_vldF, NOP); end
    rst = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_first_req got=%0h/%h exp=1/00000000", imem_req, imem_addr); end
    exp_pc = 32'h0;
  endtask

  task automatic test_basic();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    vectors++; if (imem_req !== 1'b0 || instr_vldF !== 1'b0 || instrF !== NOP) begin miscompares++; $display("FAIL basic_wait got req=%0h vld=%0h instr=%h exp 0/0/%h", imem_req, instr_vldF, instrF, NOP); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; nxt_pc = 32'h4;
    sb_q.push_back('{pc: exp_pc, pc4: exp_pc + 32'd4, instr: 32'h0050_0093});
    #1;
    vectors++; if (instrF !== 32'h0050_0093 || instr_vldF !== 1'b1) begin miscompares++; $display("FAIL basic_instrF got=%h/%0h exp=00500093/1", instrF, instr_vldF); end
    step();
    imem_rvalid = 1'b0;
    exp_e = sb_q.pop_front();
    vectors++; if (pcD !== exp_e.pc || instrD !== exp_e.instr || vldD !== 1'b1) begin miscompares++; $display("FAIL basic_ifid got=%h/%h/%0h exp=%h/%h/1", pcD, instrD, vldD, exp_e.pc, exp_e.instr); end
    vectors++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin miscompares++; $display("FAIL basic_next_addr got=%h/%0h exp=00000004/1", imem_addr, imem_req); end
    last_pc = exp_e.pc; last_instr = exp_e.instr;
    exp_pc = 32'h4;
    step();
    vectors++; if (vldD !== 1'b0 || instrD !== NOP) begin miscompares++; $display("FAIL basic_bubble got=%0h/%h exp=0/%h", vldD, instrD, NOP); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      data_v = $urandom;
      imem_rvalid = 1'b1; imem_rdata = data_v; nxt_pc = exp_pc + 32'd4;
      sb_q.push_back('{pc: exp_pc, pc4: exp_pc + 32'd4, instr: data_v});
      step();
      imem_rvalid = 1'b0;
      exp_e = sb_q.pop_front();
      vectors++; if (pcD !== exp_e.pc || pc4D !== exp_e.pc4 || instrD !== exp_e.instr || vldD !== 1'b1) begin miscompares++; $display("FAIL b2b_ifid[%0d] got=%h/%h/%h/%0h exp=%h/%h/%h/1", i, pcD, pc4D, instrD, vldD, exp_e.pc, exp_e.pc4, exp_e.instr); end
      exp_pc = exp_pc + 32'd4;
      vectors++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin miscompares++; $display("FAIL b2b_addr[%0d] got=%h/%0h exp=%h/1", i, imem_addr, imem_req, exp_pc); end
      last_pc = exp_e.pc; last_instr = exp_e.instr;
    end
  endtask

  task automatic test_stall_hold();
    imem_gnt = 1'b1; stall = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0013; nxt_pc = 32'hDEAD_0000;
    step();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; end
      else begin imem_rvalid = 1'b0; end
      #1;
      vectors++; if (instrF !== 32'hCAFE_0013 || instr_vldF !== 1'b1) begin miscompares++; $display("FAIL hold_instrF[%0d] got=%h/%0h exp=cafe0013/1", k, instrF, instr_vldF); end
      vectors++; if (vldD !== 1'b1 || instrD !== last_instr || pcD !== last_pc) begin miscompares++; $display("FAIL hold_ifid[%0d] got=%0h/%h/%h exp=1/%h/%h", k, vldD, instrD, pcD, last_instr, last_pc); end
      vectors++; if (imem_req !== 1'b0 || imem_addr !== exp_pc) begin miscompares++; $display("FAIL hold_req[%0d] got=%0h/%h exp=0/%h", k, imem_req, imem_addr, exp_pc); end
      step();
    end
    imem_rvalid = 1'b0; stall = 1'b0; nxt_pc = exp_pc + 32'd4;
    sb_q.push_back('{pc: exp_pc, pc4: exp_pc + 32'd4, instr: 32'hCAFE_0013});
    step();
    exp_e = sb_q.pop_front();
    vectors++; if (pcD !== exp_e.pc || instrD !== exp_e.instr || vldD !== 1'b1) begin miscompares++; $display("FAIL hold_release got=%h/%h/%0h exp=%h/%h/1", pcD, instrD, vldD, exp_e.pc, exp_e.instr); end
    exp_pc = exp_pc + 32'd4;
    vectors++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin miscompares++; $display("FAIL hold_next_addr got=%h/%0h exp=%h/1", imem_addr, imem_req, exp_pc); end
  endtask

  task automatic test_flush_req();
    br_flush = 1'b1; nxt_pc = 32'h300;
    step();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin miscompares++; $display("FAIL freq_stay got=%0h/%h exp=1/00000300", imem_req, imem_addr); end
    vectors++; if (vldD !== 1'b0 || instrD !== NOP) begin miscompares++; $display("FAIL freq_ifid got=%0h/%h exp=0/%h", vldD, instrD, NOP); end
    imem_gnt = 1'b1; nxt_pc = 32'h400;
    step();
    br_flush = 1'b0; imem_gnt = 1'b0;
    step();
    vectors++; if (imem_req !== 1'b0 || pcF !== 32'h400) begin miscompares++; $display("FAIL freq_drop got=%0h/%h exp=0/00000400", imem_req, pcF); end
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    #1;
    vectors++; if (instr_vldF !== 1'b0 || instrF !== NOP) begin miscompares++; $display("FAIL freq_drop_vldF got=%h/%0h exp=%h/0", instrF, instr_vldF, NOP); end
    step();
    imem_rvalid = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || vldD !== 1'b0) begin miscompares++; $display("FAIL freq_resume got=%0h/%h/%0h exp=1/00000400/0", imem_req, imem_addr, vldD); end
    exp_pc = 32'h400;
  endtask

  task automatic test_flush_wait_drop();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; br_flush = 1'b1; nxt_pc = 32'h100;
    step();
    br_flush = 1'b0; nxt_pc = 32'h0;
    vectors++; if (imem_req !== 1'b0 || instr_vldF !== 1'b0 || pcF !== 32'h100) begin miscompares++; $display("FAIL fwd_drop got=%0h/%0h/%h exp=0/0/00000100", imem_req, instr_vldF, pcF); end
    vectors++; if (vldD !== 1'b0 || instrD !== 32'h13) begin miscompares++; $display("FAIL fwd_ifid got=%0h/%h exp=0/00000013", vldD, instrD); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || vldD !== 1'b0 || instrD !== NOP) begin miscompares++; $display("FAIL fwd_resume got=%0h/%h/%0h/%h exp=1/00000100/0/%h", imem_req, imem_addr, vldD, instrD, NOP); end
    exp_pc = 32'h100;
  endtask

  task automatic test_flush_rvalid();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; br_flush = 1'b1; nxt_pc = 32'h200;
    step();
    imem_rvalid = 1'b0; br_flush = 1'b0;
    vectors++; if (vldD !== 1'b0 || instrD !== NOP) begin miscompares++; $display("FAIL frv_ifid got=%0h/%h exp=0/%h", vldD, instrD, NOP); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL frv_next got=%0h/%h exp=1/00000200", imem_req, imem_addr); end
    exp_pc = 32'h200;
  endtask

  task automatic test_wrap_align();
    br_flush = 1'b1; nxt_pc = 32'hFFFF_FFFF;
    step();
    br_flush = 1'b0;
    vectors++; if (pcF !== 32'hFFFF_FFFC || pc4F !== 32'h0 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got=%h/%h/%h exp=fffffffc/00000000/fffffffc", pcF, pc4F, imem_addr); end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113; nxt_pc = 32'h103;
    sb_q.push_back('{pc: 32'hFFFF_FFFC, pc4: 32'h0, instr: 32'h0010_0113});
    step();
    imem_rvalid = 1'b0;
    exp_e = sb_q.pop_front();
    vectors++; if (pcD !== exp_e.pc || pc4D !== exp_e.pc4 || instrD !== exp_e.instr || vldD !== 1'b1) begin miscompares++; $display("FAIL wrap_ifid got=%h/%h/%h/%0h exp=%h/%h/%h/1", pcD, pc4D, instrD, vldD, exp_e.pc, exp_e.pc4, exp_e.instr); end
    vectors++; if (pcF !== 32'h100 || pc4F !== 32'h104) begin miscompares++; $display("FAIL align_pc got=%h/%h exp=00000100/00000104", pcF, pc4F); end
    exp_pc = 32'h100;
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; rst = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req_in_rst got=%0h exp=0", imem_req); end
    step();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    #1;
    vectors++; if (instr_vldF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || vldD !== 1'b0) begin miscompares++; $display("FAIL rmid_late got=%0h/%0h/%h/%0h exp=0/1/00000000/0", instr_vldF, imem_req, imem_addr, vldD); end
    step();
    imem_rvalid = 1'b0;
    vectors++; if (vldD !== 1'b0 || instrD !== NOP || imem_addr !== 32'h0 || imem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_after got=%0h/%h/%h/%0h exp=0/%h/00000000/1", vldD, instrD, imem_addr, imem_req, NOP); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_hold();
    test_flush_req();
    test_flush_wait_drop();
    test_flush_rvalid();
    test_wrap_align();
    test_reset_mid();
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got=%0d exp=0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
